// File: rtl/frame_mapper_pkg.sv
// ---------------------------------------------------------------------------
// frame_mapper_pkg
// Constants shared by the frame mapper, corruptor and receiver deframer:
// frame geometry, FAS byte values, CRC-8 parameters and FSM state encodings.
// No ports.
// ---------------------------------------------------------------------------
package frame_mapper_pkg;

    localparam int unsigned FM_NUM_ROWS = 4;
    localparam int unsigned FM_NUM_COLS = 1041;
    localparam int unsigned FM_FAS_LEN  = 16;

    localparam int unsigned ROW_W = 2;
    localparam int unsigned COL_W = 11;

    // First half of the FAS is FAS_BYTE_A, second half FAS_BYTE_B.
    localparam logic [7:0] FAS_BYTE_A = 8'hF6;
    localparam logic [7:0] FAS_BYTE_B = 8'h28;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FAS     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CRC     = 2'd3
    } fm_state_t;

endpackage

// File: rtl/crc8_byte.sv
// ---------------------------------------------------------------------------
// crc8_byte
// Combinational CRC-8 update for one byte, MSB first, no reflection.
// Shared by the frame mapper and the receiver CRC check.
//   i_crc_in   [7:0]  current CRC value
//   i_data_in  [7:0]  byte to fold in
//   o_crc_out  [7:0]  CRC after the byte
// ---------------------------------------------------------------------------
module crc8_byte
    import frame_mapper_pkg::*;
(
    input  logic [7:0] i_crc_in,
    input  logic [7:0] i_data_in,
    output logic [7:0] o_crc_out
);

    logic [7:0] w_crc;

    // Folding the whole byte into the register first is equivalent to
    // shifting the data bits in one at a time, MSB first.
    always_comb begin
        w_crc = i_crc_in ^ i_data_in;
        for (int i = 0; i < 8; i++) begin
            if (w_crc[7]) begin
                w_crc = {w_crc[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                w_crc = {w_crc[6:0], 1'b0};
            end
        end
        o_crc_out = w_crc;
    end

endmodule

// File: rtl/frame_mapper.sv
// ---------------------------------------------------------------------------
// frame_mapper
// Builds NUM_ROWS x NUM_COLS frames: FAS bytes at the start of row 0, client
// payload bytes everywhere else, and a CRC-8 over the payload in the last
// position of the last row.
//   i_clk              clock, rising edge
//   i_rst              synchronous active-high reset
//   i_enable           frame generation enable (sampled between frames)
//   i_data[7:0]        client payload byte
//   i_data_valid       i_data valid
//   o_data_ready       payload accepted this cycle (combinational from state)
//   o_row_cnt[1:0]     row of the byte on o_pyld_data
//   o_col_cnt[10:0]    column of the byte on o_pyld_data
//   o_pyld_data[7:0]   frame byte
//   o_pyld_data_valid  o_pyld_data valid
//   o_frame_data_fas   current byte is FAS
//   o_frame_cnt[7:0]   completed frames, wraps
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no frame in progress, wait for i_enable
// ST_FAS     | emit FAS bytes, one per cycle, row 0 cols 0..FAS_LEN-1
// ST_PAYLOAD | forward accepted client bytes, hold position when none
// ST_CRC     | emit CRC byte at the last position, count the frame
// ---------------------------------------------------------------------------
module frame_mapper
    import frame_mapper_pkg::*;
#(
    parameter int NUM_ROWS = FM_NUM_ROWS,
    parameter int NUM_COLS = FM_NUM_COLS,
    parameter int FAS_LEN  = FM_FAS_LEN
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic [7:0]       i_data,
    input  logic             i_data_valid,
    output logic             o_data_ready,
    output logic [ROW_W-1:0] o_row_cnt,
    output logic [COL_W-1:0] o_col_cnt,
    output logic [7:0]       o_pyld_data,
    output logic             o_pyld_data_valid,
    output logic             o_frame_data_fas,
    output logic [7:0]       o_frame_cnt
);

    localparam logic [ROW_W-1:0] LAST_ROW      = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL      = COL_W'(NUM_COLS - 1);
    localparam logic [COL_W-1:0] LAST_PYLD_COL = COL_W'(NUM_COLS - 2);
    localparam logic [COL_W-1:0] FAS_END       = COL_W'(FAS_LEN - 1);
    localparam logic [COL_W-1:0] FAS_HALF      = COL_W'(FAS_LEN / 2);

    fm_state_t        r_state;
    logic [ROW_W-1:0] r_row;     // position of the next byte to emit
    logic [COL_W-1:0] r_col;
    logic [7:0]       r_crc;
    logic [7:0]       w_crc_next;
    logic             w_accept;

    assign o_data_ready = (r_state == ST_PAYLOAD);
    assign w_accept     = i_data_valid && o_data_ready;

    crc8_byte u_crc8_byte (
        .i_crc_in  (r_crc),
        .i_data_in (i_data),
        .o_crc_out (w_crc_next)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state           <= ST_IDLE;
            r_row             <= '0;
            r_col             <= '0;
            r_crc             <= CRC8_INIT;
            o_row_cnt         <= '0;
            o_col_cnt         <= '0;
            o_pyld_data       <= 8'h00;
            o_pyld_data_valid <= 1'b0;
            o_frame_data_fas  <= 1'b0;
            o_frame_cnt       <= 8'h00;
        end else begin
            o_pyld_data_valid <= 1'b0;
            o_frame_data_fas  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_row <= '0;
                    r_col <= '0;
                    if (i_enable) begin
                        r_state <= ST_FAS;
                    end
                end
                ST_FAS: begin
                    // FAS always fits inside row 0, so no row wrap here.
                    o_pyld_data       <= (r_col < FAS_HALF) ? FAS_BYTE_A : FAS_BYTE_B;
                    o_pyld_data_valid <= 1'b1;
                    o_frame_data_fas  <= 1'b1;
                    o_row_cnt         <= r_row;
                    o_col_cnt         <= r_col;
                    r_col             <= r_col + COL_W'(1);
                    if (r_col == '0) begin
                        r_crc <= CRC8_INIT;
                    end
                    if (r_col == FAS_END) begin
                        r_state <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_accept) begin
                        o_pyld_data       <= i_data;
                        o_pyld_data_valid <= 1'b1;
                        o_row_cnt         <= r_row;
                        o_col_cnt         <= r_col;
                        r_crc             <= w_crc_next;
                        if (r_col == LAST_COL) begin
                            r_col <= '0;
                            r_row <= r_row + ROW_W'(1);
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                        if (r_row == LAST_ROW && r_col == LAST_PYLD_COL) begin
                            r_state <= ST_CRC;
                        end
                    end
                end
                ST_CRC: begin
                    o_pyld_data       <= r_crc;
                    o_pyld_data_valid <= 1'b1;
                    o_row_cnt         <= r_row;
                    o_col_cnt         <= r_col;
                    o_frame_cnt       <= o_frame_cnt + 8'd1;
                    r_row             <= '0;
                    r_col             <= '0;
                    r_state           <= i_enable ? ST_FAS : ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_mapper.sv
// ---------------------------------------------------------------------------
// tb_frame_mapper
// Two mappers: one with the default geometry for directed frame scenarios,
// one with short rows so that 256 frames finish quickly for the wrap checks.
// Expected bytes come from a position-index frame model into per-DUT queues.
// ---------------------------------------------------------------------------
module tb_frame_mapper;

    localparam int ROWS  = 4;
    localparam int FASL  = 16;
    localparam int COLS1 = 1041;
    localparam int COLS2 = 20;
    localparam int NPYLD = ROWS * COLS1 - FASL - 1;

    typedef struct packed {
        logic [7:0]  d;
        logic [1:0]  r;
        logic [10:0] c;
        logic        f;
    } exp_t;

    typedef struct {
        bit         active;
        int         pos;
        logic [7:0] crc;
        logic [7:0] fcnt;
    } m_t;

    logic        clk = 1'b0;
    logic        rst1, en1, vld1, rst2, en2, vld2;
    logic [7:0]  data1, data2;
    logic        rdy1, pv1, fas1, rdy2, pv2, fas2;
    logic [1:0]  row1, row2;
    logic [10:0] col1, col2;
    logic [7:0]  pd1, pd2, fcnt1, fcnt2;

    int   total = 0;
    int   bad   = 0;
    m_t   m1, m2;
    exp_t q1[$];
    exp_t q2[$];
    int   max_col1 = 0;
    int   max_col2 = 0;
    logic [7:0] prev_fcnt2 = 8'h00;
    logic [1:0] prev_row2  = 2'd0;
    bit   seen_fwrap = 0;
    bit   seen_rwrap = 0;

    always #5 clk = ~clk;

    frame_mapper u_dut1 (
        .i_clk(clk), .i_rst(rst1), .i_enable(en1), .i_data(data1),
        .i_data_valid(vld1), .o_data_ready(rdy1), .o_row_cnt(row1),
        .o_col_cnt(col1), .o_pyld_data(pd1), .o_pyld_data_valid(pv1),
        .o_frame_data_fas(fas1), .o_frame_cnt(fcnt1)
    );

    frame_mapper #(.NUM_ROWS(ROWS), .NUM_COLS(COLS2), .FAS_LEN(FASL)) u_dut2 (
        .i_clk(clk), .i_rst(rst2), .i_enable(en2), .i_data(data2),
        .i_data_valid(vld2), .o_data_ready(rdy2), .o_row_cnt(row2),
        .o_col_cnt(col2), .o_pyld_data(pd2), .o_pyld_data_valid(pv2),
        .o_frame_data_fas(fas2), .o_frame_cnt(fcnt2)
    );

    // Bit-serial CRC-8, poly 0x07, MSB first.
    function automatic logic [7:0] crc_bit(logic [7:0] c, logic [7:0] d);
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    function automatic logic [7:0] ref_crc(int n);
        logic [7:0] c = 8'h00;
        for (int k = 0; k < n; k++) c = crc_bit(c, 8'(k));
        return c;
    endfunction

    function automatic bit m_ready(m_t m, int cols);
        return m.active && (m.pos >= FASL) && (m.pos < ROWS * cols - 1);
    endfunction

    task automatic model_step(inout m_t m, input int cols, input bit rst,
                              input bit en, input bit vld, input logic [7:0] d,
                              output bit push, output exp_t e);
        push = 0;
        e    = '0;
        if (rst) begin
            m.active = 0; m.pos = 0; m.crc = 8'h00; m.fcnt = 8'h00;
        end else if (!m.active) begin
            if (en) begin
                m.active = 1; m.pos = 0;
            end
        end else begin
            e.r = 2'(m.pos / cols);
            e.c = 11'(m.pos % cols);
            if (m.pos < FASL) begin
                push = 1;
                e.d  = (m.pos < FASL / 2) ? 8'hF6 : 8'h28;
                e.f  = 1'b1;
                if (m.pos == 0) m.crc = 8'h00;
                m.pos++;
            end else if (m.pos == ROWS * cols - 1) begin
                push = 1;
                e.d  = m.crc;
                m.fcnt = m.fcnt + 8'd1;
                m.pos = 0;
                m.active = en;
            end else if (vld) begin
                push  = 1;
                e.d   = d;
                m.crc = crc_bit(m.crc, d);
                m.pos++;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model both DUTs at the edge, check and drive half a cycle later.
    task automatic step();
        bit   p;
        exp_t e;
        @(posedge clk);
        model_step(m1, COLS1, rst1, en1, vld1, data1, p, e);
        if (rst1) q1.delete();
        if (p) q1.push_back(e);
        model_step(m2, COLS2, rst2, en2, vld2, data2, p, e);
        if (rst2) q2.delete();
        if (p) q2.push_back(e);
        @(negedge clk);
        if (pv1) begin
            chk("d1_have_exp", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("d1_byte", {pd1, row1, col1, fas1}, e);
            end
            if (int'(col1) > max_col1) max_col1 = int'(col1);
        end else begin
            chk("d1_idle_fas", fas1, 0);
            chk("d1_lost", q1.size(), 0);
        end
        chk("d1_ready", rdy1, m_ready(m1, COLS1));
        chk("d1_fcnt", fcnt1, m1.fcnt);
        if (pv2) begin
            chk("d2_have_exp", 32'(q2.size() != 0), 1);
            if (q2.size() != 0) begin
                e = q2.pop_front();
                chk("d2_byte", {pd2, row2, col2, fas2}, e);
            end
            if (int'(col2) > max_col2) max_col2 = int'(col2);
            if (prev_row2 == 2'd3 && row2 == 2'd0) seen_rwrap = 1;
            prev_row2 = row2;
        end else begin
            chk("d2_idle_fas", fas2, 0);
            chk("d2_lost", q2.size(), 0);
        end
        chk("d2_ready", rdy2, m_ready(m2, COLS2));
        chk("d2_fcnt", fcnt2, m2.fcnt);
        if (prev_fcnt2 == 8'd255 && fcnt2 == 8'd0) seen_fwrap = 1;
        prev_fcnt2 = fcnt2;
        data1 = 8'(m1.pos - FASL);
        vld2  = ($urandom_range(0, 7) != 0);
        data2 = 8'($urandom);
    endtask

    task automatic wait_out(string tag, logic [1:0] r, logic [10:0] c, int budget);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            if (pv1 && row1 == r && col1 == c) found = 1;
        end
        chk(tag, found, 1);
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_valid"}, pv1, 0);
        chk({tag, "_fas"},   fas1, 0);
        chk({tag, "_data"},  pd1, 8'h00);
        chk({tag, "_row"},   row1, 0);
        chk({tag, "_col"},   col1, 0);
        chk({tag, "_fcnt"},  fcnt1, 0);
        chk({tag, "_ready"}, rdy1, 0);
    endtask

    initial begin
        rst1 = 1; rst2 = 1; en1 = 0; en2 = 0; vld1 = 0; vld2 = 0;
        data1 = 8'h00; data2 = 8'h00;
        repeat (3) step();
        chk_reset("rst_init");

        rst1 = 0; rst2 = 0; en1 = 1; en2 = 1; vld1 = 1;
        wait_out("fas_first_seen", 2'd0, 11'd0, 10);
        chk("fas_first_byte", {fas1, pd1}, {1'b1, 8'hF6});
        wait_out("fas_last_seen", 2'd0, 11'd15, 20);
        chk("fas_last_byte", {fas1, pd1}, {1'b1, 8'h28});
        step();
        chk("first_pyld", {pv1, fas1, row1, col1, pd1}, {1'b1, 1'b0, 2'd0, 11'd16, 8'h00});

        wait_out("crc1_seen", 2'd3, 11'd1040, 5000);
        chk("crc1_val", {fas1, pd1}, {1'b0, ref_crc(NPYLD)});
        chk("crc1_fcnt", fcnt1, 1);
        step();
        chk("restart_fas", {pv1, fas1, row1, col1, pd1}, {1'b1, 1'b1, 2'd0, 11'd0, 8'hF6});

        wait_out("gap_seen", 2'd1, 11'd500, 5000);
        vld1 = 0;
        repeat (5) begin
            step();
            chk("gap_valid", pv1, 0);
            chk("gap_hold", {row1, col1}, {2'd1, 11'd500});
        end
        vld1 = 1;
        step();
        chk("gap_resume", {pv1, row1, col1, pd1}, {1'b1, 2'd1, 11'd501, 8'(COLS1 + 501 - FASL)});
        wait_out("crc2_seen", 2'd3, 11'd1040, 5000);
        chk("crc2_val", pd1, ref_crc(NPYLD));
        chk("crc2_fcnt", fcnt1, 2);

        wait_out("drop_seen", 2'd2, 11'd10, 5000);
        en1 = 0;
        wait_out("crc3_seen", 2'd3, 11'd1040, 5000);
        chk("crc3_val", pd1, ref_crc(NPYLD));
        chk("crc3_fcnt", fcnt1, 3);
        repeat (5) begin
            step();
            chk("idle_ready", rdy1, 0);
            chk("idle_valid", pv1, 0);
        end

        en1 = 1;
        wait_out("rst_pos_seen", 2'd3, 11'd200, 6000);
        rst1 = 1;
        step();
        chk_reset("rst_mid");
        rst1 = 0;
        wait_out("fas_after_rst", 2'd0, 11'd0, 10);
        chk("fas_after_rst_byte", {fas1, pd1}, {1'b1, 8'hF6});
        wait_out("crc5_seen", 2'd3, 11'd1040, 5000);
        chk("crc5_val", pd1, ref_crc(NPYLD));
        chk("crc5_fcnt", fcnt1, 1);
        chk("max_col1", max_col1, 1040);

        for (int i = 0; i < 60000 && !seen_fwrap; i++) step();
        chk("fcnt_wrap", seen_fwrap, 1);
        chk("row_wrap", seen_rwrap, 1);
        chk("max_col2", max_col2, COLS2 - 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_mapper.md
FRAME_MAPPER -- requirements
Module: frame_mapper

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 4, rows per frame.
REQ-002 SHALL have parameter NUM_COLS, default 1041, columns per row (col 0..1040).
REQ-003 SHALL have parameter FAS_LEN, default 16, FAS bytes at start of row 0.
REQ-004 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_enable  input  1  frame generation enable.
REQ-007 SHALL have port i_data  input  8  client payload byte.
REQ-008 SHALL have port i_data_valid  input  1  i_data valid.
REQ-009 SHALL have port o_data_ready  output  1  mapper accepts i_data this cycle.
REQ-010 SHALL have port o_row_cnt  output  2  row of the byte on o_pyld_data.
REQ-011 SHALL have port o_col_cnt  output  11  column of the byte on o_pyld_data.
REQ-012 SHALL have port o_pyld_data  output  8  frame byte to corruptor.
REQ-013 SHALL have port o_pyld_data_valid  output  1  o_pyld_data valid.
REQ-014 SHALL have port o_frame_data_fas  output  1  current byte is FAS.
REQ-015 SHALL have port o_frame_cnt  output  8  completed frames, wraps 255->0.

Function
REQ-016 SHALL use FSM states IDLE, FAS, PAYLOAD, CRC.
REQ-017 IDLE->FAS SHALL occur on first cycle with i_enable=1; counters start at row 0, col 0.
REQ-018 FAS SHALL emit one byte per cycle, unconditionally: cols 0-7 = 0xF6, cols 8-15 = 0x28, o_frame_data_fas=1.
REQ-019 FAS->PAYLOAD SHALL occur after row 0 col FAS_LEN-1.
REQ-020 PAYLOAD SHALL cover every position except FAS and row 3 col 1040; o_data_ready=1 only in PAYLOAD (combinational from state).
REQ-021 A byte SHALL be accepted when i_data_valid && o_data_ready; emitted next cycle with o_pyld_data_valid=1 and its row/col.
REQ-022 When i_data_valid=0 in PAYLOAD, SHALL emit nothing (valid=0) and hold counters; no idle fill.
REQ-023 Column SHALL advance per emitted byte; col NUM_COLS-1 wraps to 0 with row+1.
REQ-024 PAYLOAD->CRC SHALL occur after accepting row 3 col 1039; o_data_ready=0 in CRC.
REQ-025 CRC SHALL emit, at row 3 col 1040, CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR) over all payload bytes of the frame, FAS excluded.
REQ-026 After CRC, SHALL increment o_frame_cnt and go to FAS if i_enable=1, else IDLE.
REQ-027 i_enable deasserted mid-frame SHALL NOT abort; frame completes, then IDLE.
REQ-028 CRC accumulator SHALL clear at each frame's FAS col 0.
REQ-029 All outputs except o_data_ready SHALL be registered; latency input-accept to output = 1 cycle.
REQ-030 o_frame_data_fas SHALL be 0 for every non-FAS byte and whenever o_pyld_data_valid=0.

Reset
REQ-031 i_rst=1 SHALL force IDLE, o_row_cnt=0, o_col_cnt=0, o_pyld_data=0x00, o_pyld_data_valid=0, o_frame_data_fas=0, o_frame_cnt=0, CRC=0x00, o_data_ready=0.
REQ-032 Reset mid-frame SHALL discard partial frame; next frame starts from FAS col 0.

Structure
REQ-033 Frame geometry, FAS bytes (0xF6, 0x28), CRC polynomial and state encodings SHALL live in the shared constants package used by mapper, corruptor and receiver deframer.
REQ-034 CRC-8 byte update SHALL be a sub-module crc8_byte (comb next-CRC from crc_in, data_in), shared with receiver CRC check.

Verification
REQ-035 Reset, i_enable=1, i_data_valid=1 constant: first 16 outputs F6x8,28x8, fas=1, row0 col0..15; col16 ready-accepted byte appears next.
REQ-036 Continuous incrementing payload (0x00,0x01,...): row 3 col 1040 byte = reference-model CRC-8; o_frame_cnt 0->1; next cycle FAS restarts.
REQ-037 i_data_valid low 5 cycles at row 1 col 500: valid=0 five cycles, counters hold at 1/500, no byte lost or duplicated.
REQ-038 i_enable dropped at row 2 col 10: frame completes with CRC, then IDLE, ready=0, valid=0.
REQ-039 i_rst pulsed at row 3 col 200: next cycle all outputs at reset values; re-enable gives fresh FAS at row 0 col 0, CRC excludes pre-reset bytes.
REQ-040 Run 256 frames: o_frame_cnt wraps 255->0; row wraps 3->0; col never exceeds 1040.
